// File: rtl/skew_feed_ctrl_pkg.sv
// Shared types and constants for the skew feed controller.
// FLUSH_LEN is the default skew depth; the top derives its flush count from COLS.
package skew_feed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned FLUSH_LEN = 6;

endpackage

// File: rtl/skew_feed_ctrl_if.sv
// Operand buffer column-vector stream (valid/ready with a packed COLS-lane vector).
interface skew_feed_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned COLS       = 6
);
    logic                       s_valid;
    logic                       s_ready;
    logic [DATA_WIDTH*COLS-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/skew_feed_ctrl_valid_chain.sv
// Token shift register tracking which skew-register stages hold tile data.
// Bit 0 is internal only; bits 1..DEPTH line up with skew output lanes 0..DEPTH-1.
module skew_valid_chain #(
    parameter int unsigned DEPTH = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           din,
    output logic [DEPTH:1] tok
);
    logic [DEPTH:0] t_q;
    logic [DEPTH:0] t_d;

    always_comb begin
        t_d = t_q;
        if (en) begin
            t_d = {t_q[DEPTH-1:0], din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

    assign tok = t_q[DEPTH:1];
endmodule

// File: rtl/skew_feed_ctrl.sv
// Feeds column vectors into the array's row-skew register, flushes the staircase
// with zero vectors and reports per-row valid plus start/busy/done to the scheduler.
module skew_feed_ctrl
    import skew_feed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned COLS       = FLUSH_LEN,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LEN_W-1:0]           len,
    output logic                       busy,
    output logic                       done,
    skew_feed_ctrl_if.slave            s,
    input  logic                       stall,
    output logic                       skew_en,
    output logic [DATA_WIDTH*COLS-1:0] skew_din,
    output logic [COLS-1:0]            row_valid
);
    localparam logic [LEN_W-1:0] FLUSH_LAST = LEN_W'(COLS - 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             done_q, done_d;
    logic             en_q, en_d;
    logic             beat;
    logic [COLS:1]    tok;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        s.s_ready   = 1'b0;
        beat        = 1'b0;
        skew_en     = 1'b0;
        skew_din    = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        k_d        = len;
                        beat_cnt_d = '0;
                        state_d    = FEED;
                    end
                end
            end
            FEED: begin
                s.s_ready = !stall;
                beat      = s.s_valid && !stall;
                if (beat) begin
                    skew_en    = 1'b1;
                    skew_din   = s.s_data;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_d == k_q) begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                skew_en = !stall;
                if (!stall) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        en_d = skew_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
            en_q        <= en_d;
        end
    end

    // Token enters with each data beat; lane r is valid once the token sits r+1 stages in
    skew_valid_chain #(.DEPTH(COLS)) u_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skew_en),
        .din   (beat),
        .tok   (tok)
    );

    assign row_valid = tok & {COLS{en_q}};
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
endmodule

// File: tb/tb_skew_feed_ctrl.sv
// Randomized and directed bench for skew_feed_ctrl against a tile-level reference
// model that tracks beats, flush pulses and a history of pushed skew entries.
module tb_skew_feed_ctrl;
    localparam int unsigned DW = 20;
    localparam int unsigned C  = 6;
    localparam int unsigned LW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [LW-1:0]   len;
    logic            busy;
    logic            done;
    logic            stall;
    logic            skew_en;
    logic [DW*C-1:0] skew_din;
    logic [C-1:0]    row_valid;

    skew_feed_ctrl_if #(.DATA_WIDTH(DW), .COLS(C)) sif ();

    skew_feed_ctrl #(.DATA_WIDTH(DW), .COLS(C), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .s         (sif.slave),
        .stall     (stall),
        .skew_en   (skew_en),
        .skew_din  (skew_din),
        .row_valid (row_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: tile phase (0 idle, 1 feeding, 2 flushing) and counts
    int m_phase = 0;
    int m_k     = 0;
    int m_got   = 0;
    int m_fl    = 0;
    bit m_done  = 1'b0;
    bit m_prev_en = 1'b0;
    bit m_hist[$];

    int en_seen, done_seen, busy_seen;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_k = 0; m_got = 0; m_fl = 0;
        m_done = 1'b0; m_prev_en = 1'b0;
        m_hist.delete();
    endtask

    task automatic cycle(input logic st, input logic [LW-1:0] ln, input logic sv,
                         input logic sl, input bit idx_data);
        logic [DW*C-1:0] d;
        logic [DW*C-1:0] e_din;
        logic [C-1:0]    e_rv;
        bit e_rdy, e_beat, e_en;
        int n;
        @(negedge clk);
        for (int i = 0; i < int'(C); i++) begin
            if (idx_data) d[i*DW +: DW] = DW'(m_got + 1);
            else          d[i*DW +: DW] = DW'($urandom);
        end
        start = st; len = ln; sif.s_valid = sv; sif.s_data = d; stall = sl;
        #2;
        e_rdy  = (m_phase == 1) && !sl;
        e_beat = e_rdy && sv;
        e_en   = e_beat || ((m_phase == 2) && !sl);
        e_din  = e_beat ? d : '0;
        n = m_hist.size();
        for (int r = 0; r < int'(C); r++) begin
            e_rv[r] = m_prev_en && (r + 1 < n) && m_hist[n - 2 - r];
        end
        check_eq("busy",      busy,        m_phase != 0);
        check_eq("s_ready",   sif.s_ready, e_rdy);
        check_eq("skew_en",   skew_en,     e_en);
        check_eq("skew_din",  skew_din,    e_din);
        check_eq("done",      done,        m_done);
        check_eq("row_valid", row_valid,   e_rv);
        if (skew_en) en_seen++;
        if (done)    done_seen++;
        if (busy)    busy_seen++;
        // Advance the model to the state it should hold after this clock edge
        m_done = 1'b0;
        if (m_phase == 0 && st) begin
            if (ln == 0) m_done = 1'b1;
            else begin m_phase = 1; m_k = int'(ln); m_got = 0; end
        end else if (m_phase == 1 && e_beat) begin
            m_got++;
            if (m_got == m_k) begin m_phase = 2; m_fl = 0; end
        end else if (m_phase == 2 && e_en) begin
            m_fl++;
            if (m_fl == int'(C)) begin m_phase = 0; m_done = 1'b1; end
        end
        if (e_en) begin
            m_hist.push_back(e_beat);
            if (m_hist.size() > C + 2) void'(m_hist.pop_front());
        end
        m_prev_en = e_en;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; sif.s_valid = 1'b0; stall = 1'b0;
        #2;
        check_eq("rst_busy",      busy,        1'b0);
        check_eq("rst_s_ready",   sif.s_ready, 1'b0);
        check_eq("rst_row_valid", row_valid,   '0);
        check_eq("rst_skew_en",   skew_en,     1'b0);
        check_eq("rst_skew_din",  skew_din,    '0);
        check_eq("rst_done",      done,        1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_counts();
        en_seen = 0; done_seen = 0; busy_seen = 0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; stall = 1'b0;
        sif.s_valid = 1'b0; sif.s_data = '0;
        do_reset();
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Basic tile, gapless: 3 data + 6 zero pulses
        clear_counts();
        cycle(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_eq("t1_pulses", en_seen, 9);
        check_eq("t1_done",   done_seen, 1);

        // Bubble of two cycles after beat 2
        clear_counts();
        cycle(1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_eq("t2_pulses", en_seen, 10);
        check_eq("t2_done",   done_seen, 1);

        // Stall three cycles once two flush pulses have gone out
        clear_counts();
        cycle(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_eq("t3_pulses", en_seen, 9);
        check_eq("t3_done",   done_seen, 1);

        // Zero-length tile
        clear_counts();
        cycle(1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("t4_done",   done_seen, 1);
        check_eq("t4_busy",   busy_seen, 0);
        check_eq("t4_pulses", en_seen, 0);

        // Restart while busy is ignored
        clear_counts();
        cycle(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 16'd7, 1'b1, 1'b0, 1'b1);
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_eq("t5_pulses", en_seen, 9);
        check_eq("t5_done",   done_seen, 1);

        // Reset in the middle of feeding, then a clean K=2 tile
        cycle(1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        do_reset();
        clear_counts();
        cycle(1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_eq("t6_pulses", en_seen, 8);
        check_eq("t6_done",   done_seen, 1);

        // K=1 boundary
        clear_counts();
        cycle(1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
        repeat (9) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("k1_pulses", en_seen, 7);
        check_eq("k1_done",   done_seen, 1);

        // Random traffic with bubbles, stalls, restarts and rare resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle(($urandom_range(0, 5) == 0), LW'($urandom_range(0, 5)),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
